// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: verifies a length/data/checksum byte
// stream, fills the instruction store, and holds the core until the image is good.
module imem_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_in_valid,
  input  logic [7:0]            i_in_byte,
  output logic                  o_in_ready,
  input  logic [31:0]           i_fetch_pc,
  output logic [31:0]           o_fetch_instr,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic                  o_load_error,
  output logic [1:0]            o_error_code,
  output logic [DEPTH_LOG2:0]   o_words_loaded
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned IDX_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_clr_idx;
  logic [15:0]        r_len;
  logic [23:0]        r_asm;
  logic [1:0]         r_byte_pos;
  logic [7:0]         r_csum;
  logic [CNT_W-1:0]   r_words_loaded;
  logic               r_in_ready;
  logic               r_cpu_hold;
  logic               r_load_done;
  logic               r_load_error;
  logic [1:0]         r_error_code;

  logic [31:0]        r_mem [0:DEPTH-1];

  logic               w_accept;
  logic [15:0]        w_len;
  logic [31:0]        w_word;
  logic [CNT_W-1:0]   w_wl_next;
  logic               w_last_word;
  logic               w_mem_we;
  logic [IDX_W-1:0]   w_mem_addr;
  logic [31:0]        w_mem_wdata;
  logic [IDX_W-1:0]   w_fetch_idx;
  logic               w_unused;

  assign w_accept    = i_in_valid & r_in_ready;
  assign w_len       = {r_len[15:8], i_in_byte};
  assign w_word      = {r_asm, i_in_byte};
  assign w_wl_next   = r_words_loaded + CNT_W'(1);
  assign w_last_word = (16'(w_wl_next) == r_len);

  // Single store write port shared by the clear sweep and word assembly.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = r_clr_idx;
    w_mem_wdata = '0;
    if (!reset) begin
      if (r_state == S_CLEAR) begin
        w_mem_we = 1'b1;
      end else if (r_state == S_DATA && w_accept && r_byte_pos == 2'd3) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_words_loaded[IDX_W-1:0];
        w_mem_wdata = w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  // Load sequencer; status outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_CLEAR;
      r_clr_idx      <= '0;
      r_len          <= '0;
      r_asm          <= '0;
      r_byte_pos     <= '0;
      r_csum         <= '0;
      r_words_loaded <= '0;
      r_in_ready     <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
      r_error_code   <= ERR_NONE;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + IDX_W'(1);
          if (&r_clr_idx) begin
            r_state    <= S_LEN_HI;
            r_in_ready <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= i_in_byte;
            r_state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if ({1'b0, w_len} > 17'(DEPTH)) begin
              r_state      <= S_ERROR;
              r_in_ready   <= 1'b0;
              r_load_error <= 1'b1;
              r_error_code <= ERR_LEN;
            end else if (w_len == 16'd0) begin
              r_state <= S_CSUM;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum <= r_csum ^ i_in_byte;
            if (r_byte_pos == 2'd3) begin
              r_byte_pos     <= 2'd0;
              r_words_loaded <= w_wl_next;
              if (w_last_word) begin
                r_state <= S_CSUM;
              end
            end else begin
              r_asm      <= {r_asm[15:0], i_in_byte};
              r_byte_pos <= r_byte_pos + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (i_in_byte == r_csum) begin
              r_state     <= S_DONE;
              r_cpu_hold  <= 1'b0;
              r_load_done <= 1'b1;
            end else begin
              r_state      <= S_ERROR;
              r_load_error <= 1'b1;
              r_error_code <= ERR_CSUM;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Fetch ignores the byte offset and any PC bits above the store size.
  assign w_fetch_idx   = i_fetch_pc[DEPTH_LOG2+1:2];
  assign w_unused      = ^{i_fetch_pc[31:DEPTH_LOG2+2], i_fetch_pc[1:0]};
  assign o_fetch_instr = r_cpu_hold ? 32'd0 : r_mem[w_fetch_idx];

  assign o_in_ready     = r_in_ready;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_load_done    = r_load_done;
  assign o_load_error   = r_load_error;
  assign o_error_code   = r_error_code;
  assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-index stream model checked every cycle, plus
// literal expectations for clear latency, loaded words and error reporting.
module tb_imem_loader;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [1:0]  error_code;
  logic [10:0] words_loaded;

  int n_err = 0;
  int n_chk = 0;

  imem_loader #(.DEPTH_LOG2(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_in_valid    (in_valid),
    .i_in_byte     (in_byte),
    .o_in_ready    (in_ready),
    .i_fetch_pc    (fetch_pc),
    .o_fetch_instr (fetch_instr),
    .o_cpu_hold    (cpu_hold),
    .o_load_done   (load_done),
    .o_load_error  (load_error),
    .o_error_code  (error_code),
    .o_words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: position in the byte stream decides the meaning of each byte.
  bit          m_init = 0;
  int          m_clr, m_k, m_len, m_words;
  bit          m_done, m_err;
  logic [1:0]  m_code;
  logic [7:0]  m_csum;
  logic [31:0] m_part;
  logic [31:0] m_mem [DEPTH];

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1; m_clr = DEPTH; m_k = 0; m_len = 0; m_words = 0;
      m_done = 0; m_err = 0; m_code = 2'b00; m_csum = 8'h00; m_part = 32'h0;
    end else if (m_init) begin
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) foreach (m_mem[i]) m_mem[i] = 32'h0;
      end else if (!m_done && !m_err && in_valid) begin
        if (m_k == 0) begin
          m_len = int'(in_byte) * 256;
        end else if (m_k == 1) begin
          m_len = m_len + int'(in_byte);
          if (m_len > DEPTH) begin m_err = 1; m_code = 2'b01; end
        end else if (m_k < 2 + 4 * m_len) begin
          m_csum = m_csum ^ in_byte;
          m_part = {m_part[23:0], in_byte};
          if ((m_k - 2) % 4 == 3) begin
            m_mem[(m_k - 2) / 4] = m_part;
            m_words++;
          end
        end else begin
          if (in_byte == m_csum) m_done = 1;
          else begin m_err = 1; m_code = 2'b10; end
        end
        m_k++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", 32'(in_ready), 32'(m_clr == 0 && !m_done && !m_err));
      chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("load_error", 32'(load_error), 32'(m_err));
      chk("error_code", 32'(error_code), 32'(m_code));
      chk("words_loaded", 32'(words_loaded), 32'(m_words));
      chk("fetch_instr", fetch_instr, m_done ? m_mem[(fetch_pc >> 2) % DEPTH] : 32'h0);
    end
  end

  logic [7:0] g_img[$];

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 2000) begin
      @(posedge clk); #1;
      cnt++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      in_valid = 1'b0;
      in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte = b;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("ready_for_byte", 32'(in_ready), 32'd1);
    if (in_ready) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_img(input bit stalls);
    int gap;
    foreach (g_img[i]) begin
      gap = 0;
      if (stalls) gap = 1 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      send_byte(g_img[i], gap);
    end
  endtask

  task automatic two_word_img(input logic [7:0] cs);
    g_img.delete();
    g_img.push_back(8'h00); g_img.push_back(8'h02);
    g_img.push_back(8'h3C); g_img.push_back(8'h01); g_img.push_back(8'h12); g_img.push_back(8'h34);
    g_img.push_back(8'h34); g_img.push_back(8'h21); g_img.push_back(8'h00); g_img.push_back(8'h05);
    g_img.push_back(cs);
  endtask

  task automatic chk_fetch(input string name, input logic [31:0] pc, input logic [31:0] exp);
    fetch_pc = pc;
    #1;
    chk(name, fetch_instr, exp);
    fetch_pc = 32'h0000_3000;
  endtask

  task automatic chk_good_load(input string tag);
    chk({tag, "_done"}, 32'(load_done), 32'd1);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd2);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk_fetch({tag, "_pc3000"}, 32'h0000_3000, 32'h3C01_1234);
    chk_fetch({tag, "_pc3004"}, 32'h0000_3004, 32'h3421_0005);
    chk_fetch({tag, "_pc3008"}, 32'h0000_3008, 32'h0000_0000);
    chk_fetch({tag, "_pc3003"}, 32'h0000_3003, 32'h3C01_1234);
  endtask

  initial begin
    int cnt;
    logic [7:0] cs;
    logic [31:0] w;
    reset = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hAA;
    fetch_pc = 32'h0000_3000;

    // Clear latency with in_valid held high throughout.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(cnt);
    in_valid = 1'b0;
    chk("clear_latency", 32'(cnt), 32'd1024);
    chk("words_after_clear", 32'(words_loaded), 32'd0);

    // Two-word image, back-to-back.
    two_word_img(8'h0B);
    send_img(1'b0);
    chk_good_load("b2b");
    repeat (3) @(posedge clk);
    #1;

    // Same image with toggling valid and random stalls.
    do_reset();
    wait_ready(cnt);
    chk("clear_latency2", 32'(cnt), 32'd1024);
    send_img(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_good_load("stall");

    // Length overflow.
    do_reset();
    wait_ready(cnt);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    chk("ovf_error", 32'(load_error), 32'd1);
    chk("ovf_code", 32'(error_code), 32'd1);
    @(posedge clk); #1;
    chk("ovf_ready", 32'(in_ready), 32'd0);
    chk("ovf_hold", 32'(cpu_hold), 32'd1);
    chk("ovf_words", 32'(words_loaded), 32'd0);

    // Checksum mismatch.
    do_reset();
    wait_ready(cnt);
    two_word_img(8'h0C);
    send_img(1'b0);
    @(posedge clk); #1;
    chk("cs_error", 32'(load_error), 32'd1);
    chk("cs_code", 32'(error_code), 32'd2);
    chk("cs_words", 32'(words_loaded), 32'd2);
    chk_fetch("cs_held_fetch", 32'h0000_3000, 32'h0000_0000);

    // Reset mid-load, then empty image.
    do_reset();
    wait_ready(cnt);
    two_word_img(8'h0B);
    for (int i = 0; i < 7; i++) send_byte(g_img[i], 0);
    do_reset();
    wait_ready(cnt);
    chk("reclear_latency", 32'(cnt), 32'd1024);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk("empty_done", 32'(load_done), 32'd1);
    chk("empty_words", 32'(words_loaded), 32'd0);
    chk_fetch("empty_pc3000", 32'h0000_3000, 32'h0000_0000);

    // Full store: N == DEPTH.
    do_reset();
    wait_ready(cnt);
    g_img.delete();
    g_img.push_back(8'h04); g_img.push_back(8'h00);
    cs = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'(i) * 32'h9E37_79B1;
      for (int j = 3; j >= 0; j--) begin
        g_img.push_back(w[j*8 +: 8]);
        cs = cs ^ w[j*8 +: 8];
      end
    end
    g_img.push_back(cs);
    send_img(1'b0);
    chk("full_done", 32'(load_done), 32'd1);
    chk("full_words", 32'(words_loaded), 32'd1024);
    chk_fetch("full_last", 32'h0000_0FFC, 32'd1023 * 32'h9E37_79B1);
    chk_fetch("full_wrap", 32'h0000_1004, 32'h9E37_79B1);
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It receives a byte stream over a valid/ready handshake, checks a header and a checksum, and writes 32-bit instruction words into a word-addressed instruction store. The fetch stage reads the same store through a combinational port. `cpu_hold` keeps the core stalled until a complete, verified image is present.

## Interface
- `DEPTH_LOG2`, 10, log2 of instruction store depth in words (DEPTH = 1024)
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high; clock `clk`
- `in_valid`  in  1  `in_byte` is valid this cycle
- `in_byte`  in  8  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle
- `fetch_pc`  in  32  fetch byte address
- `fetch_instr`  out  32  instruction at `fetch_pc`, combinational
- `cpu_hold`  out  1  core must not advance its PC while high
- `load_done`  out  1  image loaded and verified
- `load_error`  out  1  load aborted
- `error_code`  out  2  00 none, 01 length overflow, 10 checksum mismatch
- `words_loaded`  out  11  count of words written this load

## Operation
- Stream format, all fields big-endian:
  - 2 bytes: word count N.
  - 4N bytes: instruction words, MSB first.
  - 1 byte: checksum, the XOR of all 4N data bytes. Length bytes are not included.
- A byte is accepted on a posedge where `in_valid && in_ready`. Without acceptance there is no state change.
- States:
  - CLEAR: writes 0 to `mem[clr_idx]` and increments `clr_idx` every cycle. After writing DEPTH-1, goes to LEN_HI.
  - LEN_HI: accept byte into `len[15:8]`, then go to LEN_LO.
  - LEN_LO: accept byte into `len[7:0]`.
    - If {hi,lo} > DEPTH: go to ERROR with code 01.
    - If {hi,lo} == 0: go to CSUM.
    - Otherwise go to DATA.
  - DATA: shift each accepted byte into a 24-bit assembly register and XOR it into `csum`.
    - On the 4th byte of a word, write `mem[words_loaded] <= {b0,b1,b2,b3}` and increment `words_loaded`.
    - After the word where `words_loaded+1 == N`, go to CSUM.
  - CSUM: accept a byte. If it equals `csum`, go to DONE; otherwise go to ERROR with code 10.
  - DONE, ERROR: terminal until `reset`.
- Outputs per state:
  - `in_ready` = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
  - `cpu_hold` = 1 in every state except DONE.
  - `load_done` = 1 only in DONE.
  - `load_error` = 1 only in ERROR.
- Fetch port:
  - `fetch_instr = cpu_hold ? 0 : mem[fetch_pc[DEPTH_LOG2+1:2]]`.
  - Upper PC bits are ignored, so 0x0000_3000 maps to index 0.
  - `fetch_pc[1:0]` is ignored.
- Error side effects: on ERROR, words already written stay in memory. The byte byte-byte partial word is discarded.

## Timing
- Values while `reset` is high and on the first cycle after it:
  - state = CLEAR, `clr_idx` = 0
  - `in_ready` = 0, `cpu_hold` = 1, `load_done` = 0, `load_error` = 0
  - `error_code` = 00, `words_loaded` = 0, `csum` = 0, byte position = 0
  - `fetch_instr` = 0
- Clear latency: exactly DEPTH (1024) posedges with `reset` low. `in_ready` is 1 in the cycle after the 1024th clear write.
- Minimum load time after clear: 2 + 4N + 1 accepting cycles. There is no throughput loss; one byte can be accepted per cycle.
- A memory write occurs on the posedge accepting the word's 4th byte. When not held, that word is visible on `fetch_instr` the next cycle.
- The state transition into DONE or ERROR occurs on the accepting edge. `in_ready` drops in the same following cycle.
- `reset` during any state, including mid-word, aborts the load:
  - All registers return to their reset values.
  - Memory is re-cleared by the CLEAR state.
- N == DEPTH is legal and fills the whole store. N == DEPTH+1 is an overflow.
- `words_loaded` never exceeds DEPTH. The write index cannot wrap.

## Test plan
- Reset, then hold `in_valid`=1. Required:
  - `in_ready` rises exactly 1024 cycles after reset deasserts.
  - No byte is accepted before that.
  - `cpu_hold`=1 throughout.
- Load N=0x0002, data 3C 01 12 34 34 21 00 05, checksum 0x0B, back-to-back. Required:
  - `load_done`=1, `cpu_hold`=0, `words_loaded`=2.
  - `fetch_pc` 0x3000 → 0x3C011234.
  - `fetch_pc` 0x3004 → 0x34210005.
  - `fetch_pc` 0x3008 → 0x00000000.
- Same image with `in_valid` toggling every cycle and random stalls. Required: identical final memory contents and flags, with no byte dropped or duplicated.
- Length 0x0401. Required:
  - On the LEN_LO accept edge, `load_error`=1 and `error_code`=01.
  - Then `in_ready`=0, `cpu_hold`=1, `words_loaded`=0.
- Same two-word image with checksum 0x0C. Required:
  - `load_error`=1, `error_code`=10, `words_loaded`=2.
  - `fetch_instr`=0 while held.
- Assert `reset` after 5 data bytes of a load, then reload a zero-word image (00 00, checksum 00). Required:
  - Re-clear completes in 1024 cycles.
  - `load_done`=1 after 3 accepted bytes.
  - `fetch_pc` 0x3000 → 0x00000000.
